// File: rtl/dm_responder_pkg.sv
// Shared encodings for the data-memory responder and the CPU controller that drives it.
// The CPU controller reuses SIZE_* when it decodes lb/sb into byte_en.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    localparam int LANE_W = 2;
    localparam int CNT_W  = 4;

    // Only word accesses can be misaligned; byte accesses use the lane bits as a selector.
    function automatic logic is_misaligned(input logic size, input logic [LANE_W-1:0] lane);
        return (size == SIZE_WORD) && (lane != '0);
    endfunction

endpackage

// File: rtl/dm_responder_byte_lane_unit.sv
// Byte-lane helpers: extract one little-endian lane for lb, merge one lane into a word for sb.
// Purely combinational.
module byte_lane_unit
    import dm_responder_pkg::*;
(
    input  logic [31:0]       rd_word,
    input  logic [LANE_W-1:0] lane,
    input  logic              sign_ext,
    output logic [31:0]       load_result,
    input  logic [31:0]       old_word,
    input  logic [7:0]        wbyte,
    output logic [31:0]       merged
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = rd_word[7:0];
        case (lane)
            2'd0: lane_byte = rd_word[7:0];
            2'd1: lane_byte = rd_word[15:8];
            2'd2: lane_byte = rd_word[23:16];
            2'd3: lane_byte = rd_word[31:24];
            default: lane_byte = rd_word[7:0];
        endcase
        load_result = {{24{sign_ext & lane_byte[7]}}, lane_byte};
    end

    always_comb begin
        merged = old_word;
        case (lane)
            2'd0: merged[7:0]   = wbyte;
            2'd1: merged[15:8]  = wbyte;
            2'd2: merged[23:16] = wbyte;
            2'd3: merged[31:24] = wbyte;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Word-organised data memory answering the multicycle CPU's held load/store requests
// after LAT wait cycles, with a one-cycle ready pulse carrying rdata/err.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_en,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                we_q;
    logic                size_q;
    logic                sext_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [LANE_W-1:0]   lane_q;
    logic [31:0]         wdata_q;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];
    logic [31:0]         mem_word;
    logic [31:0]         byte_load;
    logic [31:0]         byte_merged;
    logic                misaligned;
    logic                mem_we;
    logic                accept;

    // Addresses wrap: bits above the word index are deliberately ignored.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign mem_word   = mem[idx_q];
    assign misaligned = is_misaligned(size_q, lane_q);
    assign mem_we     = (state == ACCESS) && we_q && !misaligned;

    // The edge that ends the ready cycle also serves as an idle edge, so a
    // requester that keeps req high gets its next access accepted there.
    assign accept = req && ((state == IDLE) || (state == RESP));

    byte_lane_unit u_lanes (
        .rd_word     (mem_word),
        .lane        (lane_q),
        .sign_ext    (sext_q),
        .load_result (byte_load),
        .old_word    (mem_word),
        .wbyte       (wdata_q[7:0]),
        .merged      (byte_merged)
    );

    // Memory is never reset; a store commits only on the ACCESS edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= (size_q == SIZE_BYTE) ? byte_merged : wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= SIZE_WORD;
            sext_q  <= 1'b0;
            idx_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        we_q    <= we;
                        size_q  <= byte_en;
                        sext_q  <= sign_ext;
                        idx_q   <= addr[ADDR_W+1:2];
                        lane_q  <= addr[LANE_W-1:0];
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        cnt     <= LAT_CNT;
                        state   <= (LAT_CNT == '0) ? ACCESS : WAIT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready <= 1'b1;
                    err   <= misaligned;
                    if (misaligned) begin
                        rdata <= '0;
                    end else if (size_q == SIZE_BYTE) begin
                        rdata <= byte_load;
                    end else begin
                        rdata <= mem_word;
                    end
                    state <= RESP;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
